// File: rtl/l1_cache_pkg.sv
// ---------------------------------------------------------------------------
// l1_cache_pkg : shared types and constants for the L1 miss controller.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package l1_cache_pkg;

  localparam int WAYS       = 8;
  localparam int WAY_W      = $clog2(WAYS);
  // 64-byte cache lines: fills are issued on this alignment
  localparam int LINE_OFF_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_CHECK     = 3'd2,
    ST_WB_REQ    = 3'd3,
    ST_WB_WAIT   = 3'd4,
    ST_FILL_REQ  = 3'd5,
    ST_FILL_WAIT = 3'd6,
    ST_UPDATE    = 3'd7
  } st_e;

  typedef enum logic {
    MEM_FILL = 1'b0,
    MEM_WB   = 1'b1
  } mem_op_e;

endpackage

`default_nettype wire

// File: rtl/l1_stat_counter.sv
// ---------------------------------------------------------------------------
// l1_stat_counter : saturating event counter, sticks at all-ones.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module l1_stat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/l1_miss_ctrl.sv
// ---------------------------------------------------------------------------
// l1_miss_ctrl : single-request L1 sequencer (lookup, writeback, fill, install).
// Optional macro MISS_STATS_EN adds saturating hit/miss counters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module l1_miss_ctrl #(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 8,
  parameter int STAT_W = 16,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_we_i,
  output logic              resp_valid_o,
  output logic              resp_hit_o,
  output logic              tag_lookup_en_o,
  output logic [ADDR_W-1:0] tag_addr_o,
  input  logic              tag_hit_i,
  input  logic [WAY_W-1:0]  tag_hit_way_i,
  input  logic              tag_victim_dirty_i,
  input  logic [ADDR_W-1:0] tag_victim_addr_i,
  output logic              tag_wr_en_o,
  output logic [WAY_W-1:0]  tag_wr_way_o,
  output logic              tag_wr_dirty_o,
  output logic              lru_access_valid_o,
  output logic [WAY_W-1:0]  lru_access_way_o,
  input  logic [WAY_W-1:0]  lru_evict_way_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
`ifdef MISS_STATS_EN
  output logic [STAT_W-1:0] stat_hits_o,
  output logic [STAT_W-1:0] stat_misses_o,
`endif
  input  logic              mem_resp_valid_i
);

  import l1_cache_pkg::*;

  st_e               state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              hit_q, hit_d;
  logic [WAY_W-1:0]  way_q, way_d;
  mem_op_e           mreq_we_q, mreq_we_d;
  logic [ADDR_W-1:0] mreq_addr_q, mreq_addr_d;

  logic              ready_q, ready_d;
  logic              lookup_q, lookup_d;
  logic              mreq_valid_q, mreq_valid_d;
  logic              upd_q, upd_d;
  logic              tag_wr_q, tag_wr_d;

  logic [ADDR_W-1:0] fill_addr;
  assign fill_addr = {addr_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    hit_d       = hit_q;
    way_d       = way_q;
    mreq_we_d   = mreq_we_q;
    mreq_addr_d = mreq_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d = ST_LOOKUP;
          addr_d  = req_addr_i;
          we_d    = req_we_i;
        end
      end
      ST_LOOKUP: state_d = ST_CHECK;
      ST_CHECK: begin
        // Victim way and address are captured here so later LRU movement
        // cannot redirect a miss that is already in progress.
        hit_d = tag_hit_i;
        if (tag_hit_i) begin
          way_d   = tag_hit_way_i;
          state_d = ST_UPDATE;
        end else begin
          way_d = lru_evict_way_i;
          if (tag_victim_dirty_i) begin
            state_d     = ST_WB_REQ;
            mreq_we_d   = MEM_WB;
            mreq_addr_d = tag_victim_addr_i;
          end else begin
            state_d     = ST_FILL_REQ;
            mreq_we_d   = MEM_FILL;
            mreq_addr_d = fill_addr;
          end
        end
      end
      ST_WB_REQ: begin
        if (mem_req_ready_i) state_d = ST_WB_WAIT;
      end
      ST_WB_WAIT: begin
        if (mem_resp_valid_i) begin
          state_d     = ST_FILL_REQ;
          mreq_we_d   = MEM_FILL;
          mreq_addr_d = fill_addr;
        end
      end
      ST_FILL_REQ: begin
        if (mem_req_ready_i) state_d = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        if (mem_resp_valid_i) state_d = ST_UPDATE;
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave a flop directly.
  always_comb begin
    ready_d      = (state_d == ST_IDLE);
    lookup_d     = (state_d == ST_LOOKUP);
    mreq_valid_d = (state_d == ST_WB_REQ) || (state_d == ST_FILL_REQ);
    upd_d        = (state_d == ST_UPDATE);
    tag_wr_d     = upd_d && (we_d || !hit_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      hit_q        <= 1'b0;
      way_q        <= '0;
      mreq_we_q    <= MEM_FILL;
      mreq_addr_q  <= '0;
      ready_q      <= 1'b1;
      lookup_q     <= 1'b0;
      mreq_valid_q <= 1'b0;
      upd_q        <= 1'b0;
      tag_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      hit_q        <= hit_d;
      way_q        <= way_d;
      mreq_we_q    <= mreq_we_d;
      mreq_addr_q  <= mreq_addr_d;
      ready_q      <= ready_d;
      lookup_q     <= lookup_d;
      mreq_valid_q <= mreq_valid_d;
      upd_q        <= upd_d;
      tag_wr_q     <= tag_wr_d;
    end
  end

  assign req_ready_o        = ready_q;
  assign resp_valid_o       = upd_q;
  assign resp_hit_o         = hit_q;
  assign tag_lookup_en_o    = lookup_q;
  assign tag_addr_o         = addr_q;
  assign tag_wr_en_o        = tag_wr_q;
  assign tag_wr_way_o       = way_q;
  assign tag_wr_dirty_o     = we_q;
  assign lru_access_valid_o = upd_q;
  assign lru_access_way_o   = way_q;
  assign mem_req_valid_o    = mreq_valid_q;
  assign mem_req_we_o       = mreq_we_q;
  assign mem_req_addr_o     = mreq_addr_q;

`ifdef MISS_STATS_EN
  logic cnt_hit, cnt_miss;
  assign cnt_hit  = (state_q == ST_UPDATE) && hit_q;
  assign cnt_miss = (state_q == ST_UPDATE) && !hit_q;

  l1_stat_counter #(.W(STAT_W)) u_stat_hits (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (cnt_hit),
    .count_o (stat_hits_o)
  );

  l1_stat_counter #(.W(STAT_W)) u_stat_misses (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (cnt_miss),
    .count_o (stat_misses_o)
  );
`else
  logic unused_stat_w;
  assign unused_stat_w = (STAT_W > 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_l1_miss_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l1_miss_ctrl : bench for l1_miss_ctrl with behavioural tag/LRU/memory model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_l1_miss_ctrl;

  localparam int ADDR_W = 32;
  localparam int WAY_W  = 3;
`ifdef MISS_STATS_EN
  localparam int STAT_W_TB = 4;
`else
  localparam int STAT_W_TB = 16;
`endif
  localparam logic [ADDR_W-1:0] LINE_MASK = 32'h0000_003F;
  localparam logic [78:0]       RST_OUTS  = {1'b1, 78'd0};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid_i, req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic              req_ready_o, resp_valid_o, resp_hit_o, tag_lookup_en_o;
  logic [ADDR_W-1:0] tag_addr_o;
  logic              tag_hit_i, tag_victim_dirty_i;
  logic [WAY_W-1:0]  tag_hit_way_i, lru_evict_way_i;
  logic [ADDR_W-1:0] tag_victim_addr_i;
  logic              tag_wr_en_o, tag_wr_dirty_o, lru_access_valid_o;
  logic [WAY_W-1:0]  tag_wr_way_o, lru_access_way_o;
  logic              mem_req_valid_o, mem_req_ready_i, mem_req_we_o, mem_resp_valid_i;
  logic [ADDR_W-1:0] mem_req_addr_o;
`ifdef MISS_STATS_EN
  logic [STAT_W_TB-1:0] stat_hits_o, stat_misses_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1_miss_ctrl #(.ADDR_W(ADDR_W), .WAYS(8), .STAT_W(STAT_W_TB)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_addr_i         (req_addr_i),
    .req_we_i           (req_we_i),
    .resp_valid_o       (resp_valid_o),
    .resp_hit_o         (resp_hit_o),
    .tag_lookup_en_o    (tag_lookup_en_o),
    .tag_addr_o         (tag_addr_o),
    .tag_hit_i          (tag_hit_i),
    .tag_hit_way_i      (tag_hit_way_i),
    .tag_victim_dirty_i (tag_victim_dirty_i),
    .tag_victim_addr_i  (tag_victim_addr_i),
    .tag_wr_en_o        (tag_wr_en_o),
    .tag_wr_way_o       (tag_wr_way_o),
    .tag_wr_dirty_o     (tag_wr_dirty_o),
    .lru_access_valid_o (lru_access_valid_o),
    .lru_access_way_o   (lru_access_way_o),
    .lru_evict_way_i    (lru_evict_way_i),
    .mem_req_valid_o    (mem_req_valid_o),
    .mem_req_ready_i    (mem_req_ready_i),
    .mem_req_we_o       (mem_req_we_o),
    .mem_req_addr_o     (mem_req_addr_o),
`ifdef MISS_STATS_EN
    .stat_hits_o        (stat_hits_o),
    .stat_misses_o      (stat_misses_o),
`endif
    .mem_resp_valid_i   (mem_resp_valid_i)
  );

  function automatic logic [78:0] outs_vec();
    return {req_ready_o, resp_valid_o, resp_hit_o, tag_lookup_en_o, tag_addr_o,
            tag_wr_en_o, tag_wr_way_o, tag_wr_dirty_o, lru_access_valid_o,
            lru_access_way_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o};
  endfunction

  // One complete request against a model of tag array, LRU block and memory.
  // Latency counts the accept cycle as cycle 0: a hit responds in cycle 3
  // (the fourth cycle), each memory transaction adds ready wait + resp wait + 2.
  task automatic do_request(input logic [ADDR_W-1:0] addr, input logic we, input logic hit,
                            input logic [WAY_W-1:0] hway, input logic [WAY_W-1:0] evict,
                            input logic dirty, input logic [ADDR_W-1:0] vaddr,
                            input int rdly, input int rd, input bit abort_wb);
    logic [ADDR_W:0]  exp_mem[$];
    logic [ADDR_W:0]  obs_mem[$];
    logic [ADDR_W:0]  cur_req;
    logic [WAY_W-1:0] exp_way, lru_way, tw_way;
    logic             tw_dirty, obs_hit;
    int exp_lat, budget, resp_k, lookup_k, n_lookup, n_lru, n_tw;
    int bad_ready, bad_taddr, bad_stable, wcnt, rcnt;
    bit req_pend, outst;

    exp_way = hit ? hway : evict;
    if (!hit && dirty) exp_mem.push_back({1'b1, vaddr});
    if (!hit)          exp_mem.push_back({1'b0, addr & ~LINE_MASK});
    exp_lat = 3 + exp_mem.size() * (rdly + rd + 2);

    resp_k = -1; lookup_k = -10; n_lookup = 0; n_lru = 0; n_tw = 0;
    bad_ready = 0; bad_taddr = 0; bad_stable = 0; wcnt = 0; rcnt = 0;
    req_pend = 0; outst = 0; cur_req = '0; lru_way = '0; tw_way = '0;
    tw_dirty = 1'b0; obs_hit = 1'b0;

    @(posedge clk); #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready_o);
    end
    req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we;
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_addr_i = $urandom; req_we_i = 1'($urandom_range(0, 1));

    budget = exp_lat + 30;
    for (int k = 1; k <= budget; k++) begin
      if (k == lookup_k + 1) begin
        tag_hit_i = hit; tag_hit_way_i = hway; tag_victim_dirty_i = dirty;
        tag_victim_addr_i = vaddr; lru_evict_way_i = evict;
      end else begin
        tag_hit_i = 1'b0; tag_hit_way_i = WAY_W'($urandom_range(0, 7));
        tag_victim_dirty_i = 1'($urandom_range(0, 1)); tag_victim_addr_i = $urandom;
        lru_evict_way_i = WAY_W'($urandom_range(0, 7));
      end
      if (tag_lookup_en_o === 1'b1) begin n_lookup++; lookup_k = k; end
      if (req_ready_o !== 1'b0) bad_ready++;
      if (tag_addr_o !== addr) bad_taddr++;
      if (lru_access_valid_o === 1'b1) begin n_lru++; lru_way = lru_access_way_o; end
      if (tag_wr_en_o === 1'b1) begin n_tw++; tw_way = tag_wr_way_o; tw_dirty = tag_wr_dirty_o; end

      mem_resp_valid_i = 1'b0;
      if (outst) begin
        if (rcnt == rd) begin mem_resp_valid_i = 1'b1; outst = 0; end
        rcnt++;
      end else if (mem_req_valid_o !== 1'b1 && $urandom_range(0, 7) == 0) begin
        mem_resp_valid_i = 1'b1;  // stray pulse outside a wait state
      end

      mem_req_ready_i = 1'b0;
      if (mem_req_valid_o === 1'b1) begin
        if (!req_pend) begin
          req_pend = 1; wcnt = 0; cur_req = {mem_req_we_o, mem_req_addr_o};
        end else if ({mem_req_we_o, mem_req_addr_o} !== cur_req) begin
          bad_stable++;
        end
        if (wcnt >= rdly) begin
          mem_req_ready_i = 1'b1; obs_mem.push_back(cur_req);
          req_pend = 0; outst = 1; rcnt = 0;
        end
        wcnt++;
      end

      if (resp_valid_o === 1'b1) begin
        resp_k = k; obs_hit = resp_hit_o;
        break;
      end
      if (abort_wb && outst && rcnt >= 2) return;
      @(posedge clk); #1;
    end
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;

    checks++;
    if (resp_k != exp_lat) begin
      failures++;
      $display("FAIL latency: got cycle %0d (-1 = timeout) want %0d", resp_k, exp_lat);
    end
    checks++;
    if (obs_hit !== hit) begin
      failures++; $display("FAIL resp_hit: got %b want %b", obs_hit, hit);
    end
    checks++;
    if (n_lookup != 1) begin
      failures++; $display("FAIL lookup_count: got %0d want 1", n_lookup);
    end
    checks++;
    if (n_lru != 1 || lru_way !== exp_way) begin
      failures++;
      $display("FAIL lru_access: got %0d pulses way %0d want 1 pulse way %0d", n_lru, lru_way, exp_way);
    end
    checks++;
    if (n_tw != ((we || !hit) ? 1 : 0)) begin
      failures++; $display("FAIL tag_wr_count: got %0d want %0d", n_tw, (we || !hit) ? 1 : 0);
    end
    if (we || !hit) begin
      checks++;
      if (tw_way !== exp_way || tw_dirty !== we) begin
        failures++;
        $display("FAIL tag_wr_fields: got way %0d dirty %b want way %0d dirty %b", tw_way, tw_dirty, exp_way, we);
      end
    end
    checks++;
    if (obs_mem.size() != exp_mem.size()) begin
      failures++; $display("FAIL mem_req_count: got %0d want %0d", obs_mem.size(), exp_mem.size());
    end
    for (int i = 0; i < exp_mem.size() && i < obs_mem.size(); i++) begin
      checks++;
      if (obs_mem[i] !== exp_mem[i]) begin
        failures++; $display("FAIL mem_req[%0d]: got %h want %h", i, obs_mem[i], exp_mem[i]);
      end
    end
    checks++;
    if (bad_ready != 0 || bad_taddr != 0 || bad_stable != 0) begin
      failures++;
      $display("FAIL busy_stability: got ready=%0d taddr=%0d memreq=%0d bad cycles want 0", bad_ready, bad_taddr, bad_stable);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs_vec() !== RST_OUTS) begin
      failures++; $display("FAIL reset_outputs: got %h want %h", outs_vec(), RST_OUTS);
    end
`ifdef MISS_STATS_EN
    checks++;
    if (stat_hits_o !== '0 || stat_misses_o !== '0) begin
      failures++; $display("FAIL reset_stats: got %h/%h want 0/0", stat_hits_o, stat_misses_o);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef MISS_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 20; i++) do_request($urandom, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, '0, 0, 0, 0);
    checks++;
    if (stat_hits_o !== 4'hF || stat_misses_o !== 4'h0) begin
      failures++; $display("FAIL stat_saturate: got hits %0d misses %0d want 15 0", stat_hits_o, stat_misses_o);
    end
  endtask
`endif

  task automatic test_read_hit();
    do_request(32'h0000_4440, 1'b0, 1'b1, 3'd5, 3'd1, 1'b1, 32'hDEAD_0000, 0, 0, 0);
  endtask

  task automatic test_clean_read_miss();
    do_request(32'h1234_5678, 1'b0, 1'b0, 3'd7, 3'd2, 1'b0, 32'h0BAD_0000, 1, 2, 0);
  endtask

  task automatic test_dirty_write_miss();
    do_request(32'h2345_67C4, 1'b1, 1'b0, 3'd0, 3'd6, 1'b1, 32'h0000_1000, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    do_request(32'hABCD_0010, 1'b1, 1'b0, 3'd3, 3'd4, 1'b1, 32'h7700_0040, 5, 3, 0);
  endtask

  task automatic test_back_to_back();
    do_request(32'h0000_0100, 1'b1, 1'b1, 3'd2, 3'd0, 1'b0, '0, 0, 0, 0);
    do_request(32'h0000_0200, 1'b0, 1'b1, 3'd6, 3'd1, 1'b0, '0, 0, 0, 0);
    do_request(32'h0000_0300, 1'b0, 1'b0, 3'd0, 3'd7, 1'b0, '0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      do_request($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 WAY_W'($urandom_range(0, 7)), WAY_W'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 4), $urandom_range(0, 3), 0);
    end
  endtask

  task automatic test_reset_mid_wb();
    do_request(32'h0000_9000, 1'b1, 1'b0, 3'd0, 3'd4, 1'b1, 32'h0000_5000, 1, 50, 1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs_vec() !== RST_OUTS) begin
      failures++; $display("FAIL reset_mid_wb: got %h want %h", outs_vec(), RST_OUTS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_request(32'h0000_A0C0, 1'b0, 1'b0, 3'd1, 3'd3, 1'b0, '0, 0, 0, 0);
  endtask

  initial begin
    req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
    tag_hit_i = 1'b0; tag_hit_way_i = '0; tag_victim_dirty_i = 1'b0; tag_victim_addr_i = '0;
    lru_evict_way_i = '0; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
    test_reset();
`ifdef MISS_STATS_EN
    test_stats();
`endif
    test_read_hit();
    test_clean_read_miss();
    test_dirty_write_miss();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
